// File: rtl/jstk_pkg.sv
// jstk_pkg: shared widths, defaults and types for the joystick velocity filter.
package jstk_pkg;
    localparam int JSTK_W     = 10;
    localparam int VEL_W      = 11;
    localparam int CENTER_DEF = 512;

    typedef logic [VEL_W-1:0] velocity_t;
    typedef enum logic [1:0] {FILL, RUN, STALE} filt_state_t;
endpackage

// File: rtl/jstk_avg_ring.sv
// jstk_avg_ring: N-deep sample ring with running sum; clr restarts the ring so a
// simultaneous write becomes the first entry.
module jstk_avg_ring
    import jstk_pkg::*;
#(
    parameter int DATA_W   = JSTK_W,
    parameter int AVG_LOG2 = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W+AVG_LOG2-1:0] sum,
    output logic                       full,
    output logic                       last
);
    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = DATA_W + AVG_LOG2;

    logic [DATA_W-1:0]   mem_q [N];
    logic [AVG_LOG2-1:0] ptr_q, ptr_d, ptr_base;
    logic [AVG_LOG2:0]   cnt_q, cnt_d, cnt_base;
    logic [SW-1:0]       sum_q, sum_d, sum_base;
    logic [DATA_W-1:0]   oldest;

    assign sum  = sum_q;
    assign full = cnt_q[AVG_LOG2];
    assign last = cnt_q == (AVG_LOG2 + 1)'(N - 1);

    // Until the ring is full the entry being replaced counts as zero.
    always_comb begin
        ptr_base = clr ? '0 : ptr_q;
        cnt_base = clr ? '0 : cnt_q;
        sum_base = clr ? '0 : sum_q;
        oldest   = (full && !clr) ? mem_q[ptr_q] : '0;
        ptr_d    = wr ? ptr_base + 1'b1 : ptr_base;
        cnt_d    = (wr && !cnt_base[AVG_LOG2]) ? cnt_base + 1'b1 : cnt_base;
        sum_d    = wr ? sum_base + SW'(din) - SW'(oldest) : sum_base;
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[ptr_base] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end
endmodule

// File: rtl/jstk_velocity_filter.sv
// jstk_velocity_filter: averages raw joystick X samples, applies a centre deadband
// and slew limit, and falls back to CENTER when the sample stream goes stale.
module jstk_velocity_filter
    import jstk_pkg::*;
#(
    parameter int DATA_W      = JSTK_W,
    parameter int AVG_LOG2    = 3,
    parameter int CENTER      = CENTER_DEF,
    parameter int DEADBAND    = 20,
    parameter int SLEW_MAX    = 64,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_x,
    input  logic              sample_valid,
    output logic [VEL_W-1:0]  velocity,
    output logic              velocity_valid,
    output logic              stale
);
    localparam int SW   = DATA_W + AVG_LOG2;
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic signed [11:0] DB   = 12'(DEADBAND);
    localparam logic signed [11:0] SL   = 12'(SLEW_MAX);
    localparam logic signed [11:0] VMAX = 12'((1 << DATA_W) - 1);

    filt_state_t       state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              upd_q, upd_d, vv_q, vv_d;
    velocity_t         vel_q, vel_d;
    logic [SW-1:0]     sum;
    logic              ring_full, ring_last, expire;
    logic [DATA_W-1:0] avg, target;
    logic signed [11:0] dev, diff, step, nxt;

    jstk_avg_ring #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_ring (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (sample_valid && state_q == STALE),
        .wr   (sample_valid),
        .din  (sample_x),
        .sum  (sum),
        .full (ring_full),
        .last (ring_last)
    );

    assign velocity       = vel_q;
    assign velocity_valid = vv_q;
    assign stale          = state_q == STALE;

    // A sample arriving on the expiry cycle suppresses the timeout.
    always_comb begin
        expire  = !sample_valid && state_q != STALE && wd_q == WD_W'(TIMEOUT_CYC - 1);
        wd_d    = sample_valid ? '0 : (wd_q == WD_W'(TIMEOUT_CYC)) ? wd_q : wd_q + 1'b1;
        state_d = expire ? STALE
                : !sample_valid ? state_q
                : (state_q == STALE) ? FILL
                : (state_q == FILL && ring_last) ? RUN : state_q;
        upd_d   = sample_valid && state_q != STALE && (ring_full || ring_last);
        avg     = DATA_W'(sum >> AVG_LOG2);
        dev     = 12'(avg) - 12'(CENTER);
        target  = (dev >= -DB && dev <= DB) ? DATA_W'(CENTER) : avg;
        diff    = 12'(target) - 12'(vel_q);
        step    = (diff > SL) ? SL : (diff < -SL) ? -SL : diff;
        nxt     = 12'(vel_q) + step;
        vel_d   = expire ? VEL_W'(CENTER)
                : !upd_q ? vel_q
                : (nxt < 0) ? '0
                : (nxt > VMAX) ? VEL_W'(VMAX) : VEL_W'(nxt);
        vv_d    = expire || upd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            wd_q    <= '0;
            upd_q   <= 1'b0;
            vv_q    <= 1'b0;
            vel_q   <= VEL_W'(CENTER);
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            upd_q   <= upd_d;
            vv_q    <= vv_d;
            vel_q   <= vel_d;
        end
    end
endmodule
